// File: rtl/hpm_counter_unit_if.sv
// hpm_counter_unit_if: CSR access port of the HPM counter unit.
// The requester drives the access; the counter unit answers combinationally.
interface hpm_counter_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_i;
  logic [11:0]     addr_i;
  logic            we_i;
  logic [XLEN-1:0] data_i;
  logic [XLEN-1:0] data_o;
  logic            access_err_o;

  modport master (
    output req_i, addr_i, we_i, data_i,
    input  data_o, access_err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, data_i,
    output data_o, access_err_o
  );
endinterface

// File: rtl/hpm_counter_unit.sv
// hpm_counter_unit: machine hardware performance-monitor counters
// (mhpmcounter3 upward), their event selects, mcountinhibit and a
// single-cycle CSR read/write port.
// Optional feature macro: HPM_OVERFLOW_IRQ_EN adds a per-counter overflow
// (OF) bit in mhpmevent bit XLEN-1 and the registered count_irq_o output.
module hpm_counter_unit #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned NumEvents   = 32,
  parameter int unsigned CntWidth    = 64,
  parameter int unsigned IncWidth    = 2,
  parameter int unsigned XLEN        = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               debug_mode_i,
  hpm_counter_unit_if.slave                  csr,
  input  logic [NumEvents-1:0][IncWidth-1:0] events_i,
  output logic                               count_irq_o
);

  localparam int unsigned SelW = (NumEvents > 1) ? $clog2(NumEvents) : 1;

  typedef enum logic [2:0] {
    AccNone,
    AccInhibit,
    AccCntLo,
    AccCntHi,
    AccEvent,
    AccIllegal
  } acc_e;

  logic [NumCounters-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic [NumCounters-1:0][SelW-1:0]     sel_q, sel_d;
  logic [NumCounters-1:0]               inh_q, inh_d;
  logic                                 run_q, run_d;

  acc_e                                 acc_kind;
  logic [4:0]                           acc_idx;
  logic [NumCounters-1:0]               acc_hit;
  logic [NumCounters-1:0]               cnt_wen;
  logic [NumCounters-1:0]               evt_wen;
  logic [NumCounters-1:0][63:0]         cnt_ext;
  logic [NumCounters-1:0][63:0]         cnt_wr;
  logic [NumCounters-1:0][CntWidth-1:0] inc;
  logic [NumCounters-1:0][CntWidth-1:0] sum;
  logic [63:0]                          wdata64;
  logic [63:0]                          rdata64;
  logic [63:0]                          sel_val;
  logic [SelW-1:0]                      sel_wr;
  logic                                 csr_wr;

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [NumCounters-1:0]               of_q, of_d;
  logic [NumCounters-1:0]               wrap;
  logic                                 irq_q, irq_d;
`endif

  assign wdata64 = 64'(csr.data_i);
  assign csr_wr  = csr.req_i & csr.we_i;

  // The OF bit position is not part of the select value; anything out of
  // range after masking it off is stored as "no event".
  assign sel_val = wdata64 & ~(64'(1) << (XLEN - 1));
  assign sel_wr  = (sel_val < 64'(NumEvents)) ? SelW'(sel_val) : '0;

  // Classify the CSR address and extract the counter slot it targets.
  always_comb begin
    acc_kind = AccIllegal;
    acc_idx  = '0;
    if (!csr.req_i) begin
      acc_kind = AccNone;
    end else if (csr.addr_i == 12'h320) begin
      acc_kind = AccInhibit;
    end else if (csr.addr_i >= 12'hB03 && csr.addr_i <= 12'hB1F) begin
      acc_kind = AccCntLo;
      acc_idx  = 5'(csr.addr_i - 12'hB03);
    end else if (XLEN == 32 && csr.addr_i >= 12'hB83 && csr.addr_i <= 12'hB9F) begin
      acc_kind = AccCntHi;
      acc_idx  = 5'(csr.addr_i - 12'hB83);
    end else if (csr.addr_i >= 12'h323 && csr.addr_i <= 12'h33F) begin
      acc_kind = AccEvent;
      acc_idx  = 5'(csr.addr_i - 12'h323);
    end
  end

  assign csr.access_err_o = (acc_kind == AccIllegal);

  // Per-counter slot match, write enables and merged write value.
  // Slots beyond NumCounters never match, so their writes vanish silently.
  always_comb begin
    acc_hit = '0;
    cnt_wen = '0;
    evt_wen = '0;
    cnt_ext = '0;
    cnt_wr  = '0;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      acc_hit[k] = (32'(acc_idx) == k);
      cnt_wen[k] = csr_wr && acc_hit[k] && (acc_kind == AccCntLo || acc_kind == AccCntHi);
      evt_wen[k] = csr_wr && acc_hit[k] && (acc_kind == AccEvent);
      cnt_ext[k] = 64'(cnt_q[k]);
      if (acc_kind == AccCntHi) begin
        cnt_wr[k] = {wdata64[31:0], cnt_ext[k][31:0]};
      end else if (XLEN == 32) begin
        cnt_wr[k] = {cnt_ext[k][63:32], wdata64[31:0]};
      end else begin
        cnt_wr[k] = wdata64;
      end
    end
  end

  // Per-counter increment and wrapped sum for this cycle.
  always_comb begin
    inc = '0;
    sum = '0;
`ifdef HPM_OVERFLOW_IRQ_EN
    wrap = '0;
`endif
    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (run_q && !debug_mode_i && !inh_q[k] && sel_q[k] != '0) begin
        inc[k] = CntWidth'(events_i[sel_q[k]]);
      end
`ifdef HPM_OVERFLOW_IRQ_EN
      {wrap[k], sum[k]} = {1'b0, cnt_q[k]} + {1'b0, inc[k]};
`else
      sum[k] = cnt_q[k] + inc[k];
`endif
    end
  end

  // CSR read mux; everything reads zero while reset is asserted.
  always_comb begin
    rdata64 = '0;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      case (acc_kind)
        AccInhibit: rdata64[k+3] = inh_q[k];
        AccCntLo:   if (acc_hit[k]) rdata64 = cnt_ext[k];
        AccCntHi:   if (acc_hit[k]) rdata64 = {32'h0, cnt_ext[k][63:32]};
        AccEvent: begin
          if (acc_hit[k]) begin
            rdata64 = 64'(sel_q[k]);
`ifdef HPM_OVERFLOW_IRQ_EN
            rdata64[XLEN-1] = of_q[k];
`endif
          end
        end
        default: ;
      endcase
    end
    if (!rst_ni) begin
      rdata64 = '0;
    end
  end

  assign csr.data_o = rdata64[XLEN-1:0];

  // Next-state: a counter write replaces that counter's increment, and an
  // overflow in the same cycle as an OF write takes priority over it.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    inh_d = inh_q;
    run_d = 1'b1;
`ifdef HPM_OVERFLOW_IRQ_EN
    of_d  = of_q;
    irq_d = |of_q;
`endif
    for (int unsigned k = 0; k < NumCounters; k++) begin
      cnt_d[k] = cnt_wen[k] ? cnt_wr[k][CntWidth-1:0] : sum[k];
      if (evt_wen[k]) begin
        sel_d[k] = sel_wr;
      end
`ifdef HPM_OVERFLOW_IRQ_EN
      if (evt_wen[k]) begin
        of_d[k] = wdata64[XLEN-1];
      end
      if (wrap[k] && !cnt_wen[k]) begin
        of_d[k] = 1'b1;
      end
`endif
      if (csr_wr && acc_kind == AccInhibit) begin
        inh_d[k] = wdata64[k+3];
      end
    end
  end

  // State registers. run_q stays low through the first edge after reset
  // release so increments on that edge are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
      inh_q <= '0;
      run_q <= 1'b0;
`ifdef HPM_OVERFLOW_IRQ_EN
      of_q  <= '0;
      irq_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      inh_q <= inh_d;
      run_q <= run_d;
`ifdef HPM_OVERFLOW_IRQ_EN
      of_q  <= of_d;
      irq_q <= irq_d;
`endif
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  assign count_irq_o = irq_q;
`else
  assign count_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counter_unit.sv
// tb_hpm_counter_unit: randomized and directed checks of hpm_counter_unit
// against a behavioural model, plus directed checks of an XLEN=32 build.
module tb_hpm_counter_unit;

  localparam int unsigned NC = 6;
  localparam int unsigned NE = 32;

`ifdef HPM_OVERFLOW_IRQ_EN
  localparam bit OfEn = 1'b1;
`else
  localparam bit OfEn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               dbg;
  logic [NE-1:0][1:0] ev;
  logic [7:0][1:0]    ev32;
  logic               irq;
  logic               irq32;

  always #5 clk = ~clk;

  hpm_counter_unit_if #(.XLEN(64)) bus ();
  hpm_counter_unit_if #(.XLEN(32)) bus32 ();

  hpm_counter_unit #(
    .NumCounters(NC), .NumEvents(NE), .CntWidth(64), .IncWidth(2), .XLEN(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .csr(bus.slave),
    .events_i(ev), .count_irq_o(irq)
  );

  hpm_counter_unit #(
    .NumCounters(3), .NumEvents(8), .CntWidth(40), .IncWidth(2), .XLEN(32)
  ) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .csr(bus32.slave),
    .events_i(ev32), .count_irq_o(irq32)
  );

  // Behavioural model of the XLEN=64 instance.
  logic [63:0] m_cnt [NC];
  int unsigned m_sel [NC];
  bit          m_inh [NC];
  bit          m_of  [NC];
  bit          m_irq;

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic void m_read(input logic [11:0] a, output logic [63:0] d, output logic err);
    int k;
    d   = '0;
    err = 1'b0;
    if (a == 12'h320) begin
      for (int i = 0; i < NC; i++) if (m_inh[i]) d[i+3] = 1'b1;
    end else if (a >= 12'hB03 && a <= 12'hB1F) begin
      k = int'(a) - 'hB03;
      if (k < NC) d = m_cnt[k];
    end else if (a >= 12'h323 && a <= 12'h33F) begin
      k = int'(a) - 'h323;
      if (k < NC) begin
        d = 64'(m_sel[k]);
        d[63] = m_of[k];
      end
    end else begin
      err = 1'b1;
    end
  endfunction

  task automatic m_clock();
    logic [11:0] a;
    logic [63:0] d, v;
    logic [64:0] s;
    bit wr, any_of, wrapped;
    int unsigned incr;
    a  = bus.addr_i;
    d  = bus.data_i;
    wr = bus.req_i && bus.we_i;
    any_of = 1'b0;
    for (int k = 0; k < NC; k++) any_of |= m_of[k];
    for (int k = 0; k < NC; k++) begin
      incr = 0;
      wrapped = 1'b0;
      if (!dbg && m_sel[k] != 0 && !m_inh[k]) incr = ev[m_sel[k]];
      if (wr && a == 12'hB03 + k) begin
        m_cnt[k] = d;
      end else begin
        s = {1'b0, m_cnt[k]} + 65'(incr);
        m_cnt[k] = s[63:0];
        wrapped = s[64];
      end
      if (wr && a == 12'h323 + k) begin
        v = d;
        v[63] = 1'b0;
        m_sel[k] = (v < 64'(NE)) ? 32'(v) : 0;
        m_of[k] = OfEn && d[63];
      end
      if (OfEn && wrapped) m_of[k] = 1'b1;
      if (wr && a == 12'h320) m_inh[k] = d[k+3];
    end
    m_irq = OfEn && any_of;
  endtask

  // One clock cycle: inputs already driven just after the falling edge.
  task automatic step();
    logic [63:0] ed;
    logic ee;
    #2;
    m_read(bus.addr_i, ed, ee);
    if (bus.req_i) begin
      check_eq($sformatf("rd_%h", bus.addr_i), bus.data_o, ed);
      check_eq($sformatf("err_%h", bus.addr_i), 64'(bus.access_err_o), 64'(ee));
    end else begin
      check_eq("err_idle", 64'(bus.access_err_o), 64'(0));
    end
    check_eq("irq", 64'(irq), 64'(m_irq));
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
  endtask

  task automatic bus32_idle();
    bus32.req_i = 1'b0; bus32.we_i = 1'b0; bus32.addr_i = '0; bus32.data_i = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr64(input logic [11:0] a, input logic [63:0] d);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d;
    step();
    bus_idle();
  endtask

  task automatic probe64(input logic [11:0] a);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
    step();
    bus_idle();
  endtask

  task automatic rd64(input logic [11:0] a, input logic [63:0] exp, input logic exp_err);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
    #1;
    check_eq($sformatf("const_rd_%h", a), bus.data_o, exp);
    check_eq($sformatf("const_err_%h", a), 64'(bus.access_err_o), 64'(exp_err));
    step();
    bus_idle();
  endtask

  task automatic wr32(input logic [11:0] a, input logic [31:0] d);
    bus32.req_i = 1'b1; bus32.we_i = 1'b1; bus32.addr_i = a; bus32.data_i = d;
    step();
    bus32_idle();
  endtask

  task automatic rd32(input logic [11:0] a, input logic [31:0] exp, input logic exp_err);
    bus32.req_i = 1'b1; bus32.we_i = 1'b0; bus32.addr_i = a;
    #1;
    check_eq($sformatf("x32_rd_%h", a), 64'(bus32.data_o), 64'(exp));
    check_eq($sformatf("x32_err_%h", a), 64'(bus32.access_err_o), 64'(exp_err));
    step();
    bus32_idle();
  endtask

  // Asynchronous reset with a counter read held on the bus throughout.
  task automatic apply_reset();
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'hB03;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_rd", bus.data_o, 64'(0));
    check_eq("rst_async_irq", 64'(irq), 64'(0));
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = '0; m_sel[k] = 0; m_inh[k] = 1'b0; m_of[k] = 1'b0;
    end
    m_irq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_rd", bus.data_o, 64'(0));
    ev = '0;
    dbg = 1'b0;
    rst_n = 1'b1;
    bus_idle();
    step();
  endtask

  task automatic random_cycle();
    int unsigned r;
    logic [11:0] a;
    logic [63:0] d;
    for (int e = 0; e < NE; e++) ev[e] = 2'($urandom_range(0, 3));
    dbg = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 9) < 3) begin
      bus_idle();
    end else begin
      r = $urandom_range(0, 9);
      case (r)
        0:       a = 12'h320;
        1, 2, 3: a = 12'(12'hB03 + $urandom_range(0, 8));
        4, 5:    a = 12'(12'h323 + $urandom_range(0, 8));
        6:       a = 12'(12'hB83 + $urandom_range(0, 3));
        7:       a = 12'h7FF;
        8:       a = 12'(12'hB00 + $urandom_range(0, 2));
        default: a = 12'($urandom_range(0, 4095));
      endcase
      if (a >= 12'h323 && a <= 12'h33F) begin
        d = 64'($urandom_range(0, 40));
        d[63] = ($urandom_range(0, 3) == 0);
      end else if (a >= 12'hB03 && a <= 12'hB1F && $urandom_range(0, 2) == 0) begin
        d = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
      end else begin
        d = {$urandom, $urandom};
      end
      bus.req_i  = 1'b1;
      bus.we_i   = ($urandom_range(0, 9) < 4);
      bus.addr_i = a;
      bus.data_i = d;
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    dbg   = 1'b0;
    ev    = '0;
    ev32  = '0;
    bus_idle();
    bus32_idle();
    @(negedge clk);
    apply_reset();

    // Selected event counts, unselected counter stays at zero.
    wr64(12'h323, 64'd5);
    ev[5] = 2'd2;
    idle_cycles(10);
    ev = '0;
    rd64(12'hB03, 64'd20, 1'b0);
    rd64(12'hB04, 64'd0, 1'b0);

    // Inhibit and debug freeze.
    wr64(12'hB03, 64'd0);
    wr64(12'hB04, 64'd0);
    wr64(12'h324, 64'd5);
    wr64(12'h320, 64'h8);
    ev[5] = 2'd1;
    idle_cycles(3);
    dbg = 1'b1;
    idle_cycles(3);
    dbg = 1'b0;
    ev = '0;
    rd64(12'hB03, 64'd0, 1'b0);
    rd64(12'hB04, 64'd3, 1'b0);
    wr64(12'h320, 64'h0);
    ev[5] = 2'd1;
    step();
    ev = '0;
    rd64(12'hB03, 64'd1, 1'b0);
    rd64(12'hB04, 64'd4, 1'b0);

    // Wrap through all-ones, OF and interrupt, then OF clear.
    wr64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
    ev[5] = 2'd1;
    idle_cycles(3);
    ev = '0;
    rd64(12'hB03, 64'd1, 1'b0);
    rd64(12'h323, 64'd5 | (64'(OfEn) << 63), 1'b0);
    wr64(12'h323, 64'd5);
    idle_cycles(2);

    // A counter write overrides that cycle's increment only.
    ev[5] = 2'd1;
    wr64(12'hB03, 64'h100);
    ev = '0;
    rd64(12'hB03, 64'h100, 1'b0);
    probe64(12'hB04);

    // WARL select, illegal and unimplemented addresses, inhibit mask.
    wr64(12'h323, 64'(NE + 3));
    rd64(12'h323, 64'd0, 1'b0);
    rd64(12'h7FF, 64'd0, 1'b1);
    rd64(12'hB83, 64'd0, 1'b1);
    rd64(12'hB0A, 64'd0, 1'b0);
    wr64(12'hB0A, 64'h55);
    rd64(12'hB0A, 64'd0, 1'b0);
    wr64(12'h320, 64'hFFFF_FFFF);
    rd64(12'h320, 64'h1F8, 1'b0);
    wr64(12'h320, 64'h0);

    // Reset in the middle of counting.
    wr64(12'h323, 64'd2);
    ev[2] = 2'd3;
    idle_cycles(4);
    apply_reset();
    rd64(12'hB03, 64'd0, 1'b0);
    rd64(12'h323, 64'd0, 1'b0);

    for (int i = 0; i < 500; i++) random_cycle();
    bus_idle();
    ev  = '0;
    dbg = 1'b0;
    step();

    // XLEN=32 instance: split halves, carry across halves, width limits.
    wr32(12'hB83, 32'hA);
    wr32(12'hB03, 32'h5);
    rd32(12'hB83, 32'hA, 1'b0);
    rd32(12'hB03, 32'h5, 1'b0);
    wr32(12'h323, 32'd1);
    wr32(12'hB03, 32'hFFFF_FFFF);
    ev32[1] = 2'd1;
    step();
    ev32 = '0;
    rd32(12'hB03, 32'h0, 1'b0);
    rd32(12'hB83, 32'hB, 1'b0);
    rd32(12'hB86, 32'h0, 1'b0);
    rd32(12'hB80, 32'h0, 1'b1);
    wr32(12'hB83, 32'hFFFF_FFFF);
    rd32(12'hB83, 32'hFF, 1'b0);
    wr32(12'h323, 32'd9);
    rd32(12'h323, 32'd0, 1'b0);
    wr32(12'h323, 32'd7);
    rd32(12'h323, 32'd7, 1'b0);
    check_eq("x32_irq", 64'(irq32), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/hpm_counter_unit.md
HPM_COUNTER_UNIT -- requirements
Module: hpm_counter_unit

Interface
REQ-001 SHALL have parameter NumCounters, default 6, giving the number of implemented mhpmcounters starting at mhpmcounter3 (legal range 1..29).
REQ-002 SHALL have parameter NumEvents, default 32, giving the number of event inputs; select code 0 is always "no event".
REQ-003 SHALL have parameter CntWidth, default 64, giving the implemented counter width (legal range 32..64).
REQ-004 SHALL have parameter IncWidth, default 2, giving the per-cycle increment width per event (multi-commit-port counts).
REQ-005 SHALL have parameter XLEN, default 64, giving the CSR data width (32 or 64).
REQ-006 clk_i  in  1  clock; all state on rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 debug_mode_i  in  1  high freezes all counting.
REQ-009 req_i  in  1  CSR access valid this cycle.
REQ-010 addr_i  in  12  CSR address.
REQ-011 we_i  in  1  write when req_i high; read otherwise.
REQ-012 data_i  in  XLEN  write data.
REQ-013 data_o  out  XLEN  read data, combinational from current state.
REQ-014 access_err_o  out  1  illegal access, combinational, valid with req_i.
REQ-015 events_i  in  NumEvents x IncWidth  per-event increment this cycle; entry 0 ignored.
REQ-016 count_irq_o  out  1  registered local counter-overflow interrupt.

Function
REQ-017 Each counter k SHALL add events_i[sel_k] per cycle, zero-extended, unless sel_k=0, inhibit bit k+3 is set, or debug_mode_i is high.
REQ-018 Counters SHALL wrap modulo 2^CntWidth; reads SHALL zero-extend to 64 bits.
REQ-019 Address map: mhpmcounterN 0xB03+k, mhpmcounterNh 0xB83+k, mhpmeventN 0x323+k, mcountinhibit 0x320.
REQ-020 Reads SHALL return pre-increment register value in the same cycle, no wait states.
REQ-021 Writes SHALL take effect at the next edge; a CSR write to counter k SHALL override that cycle's increment of counter k; other counters still count.
REQ-022 XLEN=32: low-half write SHALL preserve bits [63:32]; high-half write SHALL preserve bits [31:0]. XLEN=64: full-width write; any 0xB8x access SHALL raise access_err_o with no state change.
REQ-023 Event select field SHALL be WARL, width clog2(NumEvents); written values >= NumEvents SHALL store 0.
REQ-024 Addresses for counters 3+NumCounters..31 SHALL read 0, ignore writes, and raise no error.
REQ-025 mcountinhibit bits [2:0] and unimplemented bits SHALL read 0; implemented bits SHALL be read/write.
REQ-026 Any address outside REQ-019 with req_i high SHALL give data_o=0 and access_err_o=1 with no state change; access_err_o=0 when req_i is low.

Reset
REQ-027 On rst_ni low, all counters, event selects, inhibit bits, OF bits and count_irq_o SHALL clear to 0 immediately; data_o SHALL read 0 for all addresses during reset; increments on the deasserting edge SHALL be dropped.

Configuration
REQ-028 Macro HPM_OVERFLOW_IRQ_EN defined: counter k SHALL set OF bit (mhpmevent bit XLEN-1) on wrap from all-ones; count_irq_o SHALL be the registered OR of OF bits. Software SHALL clear OF by writing 0; an overflow in the same cycle as that write SHALL win.
REQ-029 HPM_OVERFLOW_IRQ_EN undefined: OF bits SHALL read 0, writes to them SHALL be ignored, and count_irq_o SHALL be tied 0.

Verification
REQ-030 Set sel3=5, drive events_i[5]=2 for 10 cycles -> mhpmcounter3 reads 20; mhpmcounter4 (sel 0) reads 0.
REQ-031 Set mcountinhibit=0x8, then debug_mode_i=1 on counter4 -> both counters hold their values; clearing releases counting on the next cycle.
REQ-032 Write counter3=2^CntWidth-2, events_i=1 for 3 cycles -> reads 1; with macro defined, OF bit set and count_irq_o=1 one cycle after the wrap; write OF=0 -> irq drops.
REQ-033 Write counter3=0x100 while its event fires -> next read 0x100; counter4 still increments.
REQ-034 XLEN=32: write 0xB83=0xA, then 0xB03=0x5 -> 0xB83 reads 0xA and 0xB03 reads 0x5; XLEN=64 access to 0xB83 -> access_err_o=1.
REQ-035 Write sel=NumEvents+3 -> reads 0; read 0x7FF -> data_o=0, access_err_o=1; assert reset mid-count -> all reads 0.
